// File: rtl/rca_word_sequencer.sv
// Multi-cycle WIDTH-bit adder that streams one nibble per clock through a single
// shared 4-bit ripple-carry slice, with valid/ready handshakes on both sides.

module ripple_carry_adder (
    input  logic [3:0] x,
    input  logic [3:0] y,
    input  logic       ci,
    output logic [3:0] s,
    output logic       co
);
    always_comb begin
        logic cc;
        cc = ci;
        s  = '0;
        for (int i = 0; i < 4; i++) begin
            s[i] = x[i] ^ y[i] ^ cc;
            cc   = (x[i] & y[i]) | (cc & (x[i] ^ y[i]));
        end
        co = cc;
    end
endmodule

module rca_word_sequencer #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);
    localparam int NSLICE = WIDTH / 4;
    localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [IDXW-1:0] LAST = IDXW'(NSLICE - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t            state;
    logic [IDXW-1:0]   idx;
    logic              carry;
    logic [WIDTH-1:0]  op_a;
    logic [WIDTH-1:0]  op_b;
    logic [IDXW+1:0]   sh;
    logic [3:0]        slice_a;
    logic [3:0]        slice_b;
    logic [3:0]        slice_s;
    logic              slice_c;

    // Bit offset of the current nibble; shifting avoids out-of-range part-selects.
    assign sh      = {idx, 2'b00};
    assign slice_a = 4'(op_a >> sh);
    assign slice_b = 4'(op_b >> sh);

    ripple_carry_adder u_slice (
        .x  (slice_a),
        .y  (slice_b),
        .ci (carry),
        .s  (slice_s),
        .co (slice_c)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            idx       <= '0;
            carry     <= 1'b0;
            op_a      <= '0;
            op_b      <= '0;
            sum       <= '0;
            cout      <= 1'b0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        op_a     <= a;
                        op_b     <= b;
                        carry    <= cin;
                        sum      <= '0;
                        idx      <= '0;
                        state    <= RUN;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                RUN: begin
                    // sum was cleared on accept, so OR-ing in each nibble is a write.
                    sum   <= sum | (WIDTH'(slice_s) << sh);
                    carry <= slice_c;
                    idx   <= idx + 1'b1;
                    if (idx == LAST) begin
                        cout      <= slice_c;
                        state     <= DONE;
                        out_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_rca_word_sequencer.sv
// Bench for rca_word_sequencer: directed and random additions on 16-bit and
// 4-bit instances, compared against plain integer addition.

module tb_rca_word_sequencer;
    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b0, cin = 1'b0, cout, busy;
    logic [15:0] a = '0, b = '0, sum;

    logic        in_valid4 = 1'b0, in_ready4, out_valid4, out_ready4 = 1'b0, cin4 = 1'b0, cout4, busy4;
    logic [3:0]  a4 = '0, b4 = '0, sum4;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rca_word_sequencer #(.WIDTH(16)) dut16 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .busy(busy)
    );

    rca_word_sequencer #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4),
        .a(a4), .b(b4), .cin(cin4), .out_valid(out_valid4), .out_ready(out_ready4),
        .sum(sum4), .cout(cout4), .busy(busy4)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One 16-bit transaction: accept, latency, result, hold under backpressure, release.
    task automatic op16(input logic [15:0] ta, input logic [15:0] tb, input logic tc, input int hold);
        logic [16:0] ref_full;
        int lat;
        ref_full = 17'(ta) + 17'(tb) + 17'(tc);
        @(negedge clk);
        chk("w16_in_ready_idle", 32'(in_ready), 32'd1);
        in_valid = 1'b1; a = ta; b = tb; cin = tc;
        @(negedge clk);
        in_valid = 1'b0;
        chk("w16_busy_after_accept", 32'(busy), 32'd1);
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk("w16_latency", 32'(lat), 32'd4);
        chk("w16_sum", 32'(sum), 32'(ref_full[15:0]));
        chk("w16_cout", 32'(cout), 32'(ref_full[16]));
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1; a = 16'(~ta); b = 16'(~tb);
            @(negedge clk);
            chk("w16_hold_valid", 32'(out_valid), 32'd1);
            chk("w16_hold_in_ready", 32'(in_ready), 32'd0);
            chk("w16_hold_sum", 32'(sum), 32'(ref_full[15:0]));
            chk("w16_hold_cout", 32'(cout), 32'(ref_full[16]));
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("w16_release_valid", 32'(out_valid), 32'd0);
        chk("w16_release_in_ready", 32'(in_ready), 32'd1);
        chk("w16_release_busy", 32'(busy), 32'd0);
    endtask

    task automatic op4(input logic [3:0] ta, input logic [3:0] tb, input logic tc);
        logic [4:0] ref_full;
        int lat;
        ref_full = 5'(ta) + 5'(tb) + 5'(tc);
        @(negedge clk);
        chk("w4_in_ready_idle", 32'(in_ready4), 32'd1);
        in_valid4 = 1'b1; a4 = ta; b4 = tb; cin4 = tc;
        @(negedge clk);
        in_valid4 = 1'b0;
        lat = 0;
        while (!out_valid4 && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        chk("w4_latency", 32'(lat), 32'd1);
        chk("w4_sum", 32'(sum4), 32'(ref_full[3:0]));
        chk("w4_cout", 32'(cout4), 32'(ref_full[4]));
        out_ready4 = 1'b1;
        @(negedge clk);
        out_ready4 = 1'b0;
        chk("w4_release_valid", 32'(out_valid4), 32'd0);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_sum", 32'(sum), 32'd0);
        chk("rst_cout", 32'(cout), 32'd0);
        chk("rst_w4_in_ready", 32'(in_ready4), 32'd1);

        op16(16'h0003, 16'h000C, 1'b0, 0);
        op16(16'hFFFF, 16'h0001, 1'b0, 0);
        op16(16'hA5A5, 16'h5A5A, 1'b1, 0);
        op16(16'h8000, 16'h8000, 1'b1, 5);

        // Reset while idx==2: partial result must vanish immediately.
        @(negedge clk);
        in_valid = 1'b1; a = 16'hFFFF; b = 16'hFFFF; cin = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_sum", 32'(sum), 32'd0);
        chk("midrst_cout", 32'(cout), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        op16(16'h1234, 16'h1111, 1'b0, 0);

        for (int n = 0; n < 20; n++)
            op16(16'($urandom), 16'($urandom), 1'($urandom), int'($urandom_range(0, 3)));

        op4(4'b1010, 4'b1101, 1'b1);
        op4(4'b1111, 4'b0000, 1'b1);
        op4(4'b0000, 4'b0000, 1'b0);
        for (int n = 0; n < 12; n++)
            op4(4'($urandom), 4'($urandom), 1'($urandom));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end
endmodule
